bsg_link_credit_to_ready_and_multi: RTL and testbench

- Multi-channel successor to the single-link response credit-to-ready_and adapter used between the host/endpoint side and the manycore links in the gateway core complex.
- Accepts num_ch_p credit-flow-controlled input channels and buffers each in its own FIFO.
- Presents the buffered data either as num_ch_p independent ready_and outputs, or (merge_p=1) as one round-robin-arbitrated ready_and output.
- Adds per-channel occupancy reporting, sticky overflow detection and optionally registered credit return.

---
 rtl/bsg_link_credit_to_ready_and_multi.sv | 178 +++++++++++++++++
 tb/tb_bsg_link_credit_to_ready_and_multi.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_link_credit_to_ready_and_multi.sv
// bsg_link_credit_to_ready_and_multi
//
// Converts num_ch_p credit-flow-controlled input channels into ready_and
// outputs. Each channel is buffered in its own els_p-deep FIFO. The
// upstream starts out holding els_p credits per channel. Every dequeued
// entry returns one credit, either in the dequeue cycle or one cycle later
// (credit_reg_p). With merge_p=1 all channels are round-robin arbitrated
// onto output slot 0.
//
// Ports:
//   clk_i             clock
//   reset_n_i         asynchronous active-low reset
//   v_i / data_i      per-channel input valid and payload (credit protocol)
//   credit_o          per-channel one-cycle credit-return pulse
//   v_o / data_o      per-channel output valid and payload (slot 0 only when merged)
//   ready_and_i       downstream ready (bit 0 only when merged)
//   count_o           per-channel FIFO occupancy
//   overflow_o        sticky flag: enqueue attempted on a full FIFO
//   clear_overflow_i  synchronous clear of all overflow flags
module bsg_link_credit_to_ready_and_multi #(
  parameter int num_ch_p      = 4,
  parameter int width_p       = 32,
  parameter int els_p         = 3,
  parameter int merge_p       = 0,
  parameter int credit_reg_p  = 0,
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_ch_p-1:0]              v_i,
  input  logic [num_ch_p*width_p-1:0]      data_i,
  output logic [num_ch_p-1:0]              credit_o,
  output logic [num_ch_p-1:0]              v_o,
  output logic [num_ch_p*width_p-1:0]      data_o,
  input  logic [num_ch_p-1:0]              ready_and_i,
  output logic [num_ch_p*cnt_width_lp-1:0] count_o,
  output logic [num_ch_p-1:0]              overflow_o,
  input  logic                             clear_overflow_i
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam int ch_width_lp  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;

  logic [width_p-1:0]      mem_r    [num_ch_p][els_p];
  logic [ptr_width_lp-1:0] rd_ptr_r [num_ch_p];
  logic [ptr_width_lp-1:0] wr_ptr_r [num_ch_p];
  logic [cnt_width_lp-1:0] cnt_r    [num_ch_p];
  logic [width_p-1:0]      head     [num_ch_p];
  logic [num_ch_p-1:0]     nonempty, full, deq, enq, ovf_set, overflow_r;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    nonempty = '0;
    full     = '0;
    head     = '{default: '0};
    for (int c = 0; c < num_ch_p; c++) begin
      nonempty[c] = (cnt_r[c] != '0);
      full[c]     = (cnt_r[c] == cnt_width_lp'(els_p));
      head[c]     = mem_r[c][rd_ptr_r[c]];
    end
  end

  // A full FIFO still accepts a word when its head leaves in the same cycle.
  always_comb begin
    enq     = '0;
    ovf_set = '0;
    for (int c = 0; c < num_ch_p; c++) begin
      enq[c]     = v_i[c] & (~full[c] | deq[c]);
      ovf_set[c] = v_i[c] & full[c] & ~deq[c];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < num_ch_p; c++) begin
      if (enq[c]) mem_r[c][wr_ptr_r[c]] <= data_i[c*width_p +: width_p];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_ch_p; c++) begin
        rd_ptr_r[c] <= '0;
        wr_ptr_r[c] <= '0;
        cnt_r[c]    <= '0;
      end
      overflow_r <= '0;
    end else begin
      for (int c = 0; c < num_ch_p; c++) begin
        if (enq[c]) wr_ptr_r[c] <= ptr_inc(wr_ptr_r[c]);
        if (deq[c]) rd_ptr_r[c] <= ptr_inc(rd_ptr_r[c]);
        if (enq[c] && !deq[c])      cnt_r[c] <= cnt_r[c] + 1'b1;
        else if (deq[c] && !enq[c]) cnt_r[c] <= cnt_r[c] - 1'b1;
        // A new overflow wins over a simultaneous clear.
        if (ovf_set[c])            overflow_r[c] <= 1'b1;
        else if (clear_overflow_i) overflow_r[c] <= 1'b0;
      end
    end
  end

  assign overflow_o = overflow_r;

  always_comb begin
    count_o = '0;
    for (int c = 0; c < num_ch_p; c++) begin
      count_o[c*cnt_width_lp +: cnt_width_lp] = cnt_r[c];
    end
  end

  if (merge_p != 0) begin : g_merge
    logic [ch_width_lp-1:0] rr_ptr_r, lock_grant_r, grant;
    logic                   lock_r, any_v, hs, found;
    int                     idx;

    // First non-empty channel at or after the pointer, unless a grant is
    // already presented and waiting for its handshake.
    always_comb begin
      grant = rr_ptr_r;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < num_ch_p; i++) begin
        idx = (int'(rr_ptr_r) + i) % num_ch_p;
        if (!found && nonempty[idx]) begin
          grant = ch_width_lp'(idx);
          found = 1'b1;
        end
      end
      if (lock_r) grant = lock_grant_r;
    end

    assign any_v = |nonempty;
    assign hs    = any_v & ready_and_i[0];

    always_comb begin
      v_o                 = '0;
      v_o[0]              = any_v;
      data_o              = '0;
      data_o[width_p-1:0] = head[grant];
      deq                 = '0;
      deq[grant]          = hs;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        rr_ptr_r     <= '0;
        lock_r       <= 1'b0;
        lock_grant_r <= '0;
      end else begin
        lock_r       <= any_v & ~ready_and_i[0];
        lock_grant_r <= grant;
        if (hs) rr_ptr_r <= (grant == ch_width_lp'(num_ch_p - 1)) ? '0 : grant + 1'b1;
      end
    end
  end else begin : g_indep
    always_comb begin
      v_o    = nonempty;
      deq    = nonempty & ready_and_i;
      data_o = '0;
      for (int c = 0; c < num_ch_p; c++) begin
        data_o[c*width_p +: width_p] = head[c];
      end
    end
  end

  if (credit_reg_p != 0) begin : g_credit_reg
    logic [num_ch_p-1:0] credit_r;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) credit_r <= '0;
      else            credit_r <= deq;
    end
    assign credit_o = credit_r;
  end else begin : g_credit_comb
    assign credit_o = deq;
  end

endmodule

// File: tb/tb_bsg_link_credit_to_ready_and_multi.sv
module tb_bsg_link_credit_to_ready_and_multi;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // dut_a: defaults, dut_m: merge mode, dut_c: registered credit
  logic [3:0]   v_a, credit_a, vo_a, rdy_a, ovf_a;
  logic [127:0] din_a, dout_a;
  logic [7:0]   cnt_a;
  logic         clr_a;

  logic [3:0]   v_m, credit_m, vo_m, rdy_m, ovf_m;
  logic [127:0] din_m, dout_m;
  logic [7:0]   cnt_m;
  logic         clr_m;

  logic [3:0]   v_c, credit_c, vo_c, rdy_c, ovf_c;
  logic [127:0] din_c, dout_c;
  logic [7:0]   cnt_c;
  logic         clr_c;

  bsg_link_credit_to_ready_and_multi dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a), .data_i(din_a), .credit_o(credit_a),
    .v_o(vo_a), .data_o(dout_a), .ready_and_i(rdy_a), .count_o(cnt_a),
    .overflow_o(ovf_a), .clear_overflow_i(clr_a));

  bsg_link_credit_to_ready_and_multi #(.merge_p(1)) dut_m (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_m), .data_i(din_m), .credit_o(credit_m),
    .v_o(vo_m), .data_o(dout_m), .ready_and_i(rdy_m), .count_o(cnt_m),
    .overflow_o(ovf_m), .clear_overflow_i(clr_m));

  bsg_link_credit_to_ready_and_multi #(.credit_reg_p(1)) dut_c (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_c), .data_i(din_c), .credit_o(credit_c),
    .v_o(vo_c), .data_o(dout_c), .ready_and_i(rdy_c), .count_o(cnt_c),
    .overflow_o(ovf_c), .clear_overflow_i(clr_c));

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v_a = 4'b1111; v_m = 4'b1111; v_c = 4'b1111;
    rdy_a = 4'b1111; rdy_m = 4'b1111; rdy_c = 4'b1111;
    din_a = '1; din_m = '1; din_c = '1;
    clr_a = 1'b0; clr_m = 1'b0; clr_c = 1'b0;
    repeat (3) tick();
    mid();
    checks++; if (vo_a !== 4'b0) begin errors++; $display("FAIL reset_vo_a: got %b expected 0000", vo_a); end
    checks++; if (credit_a !== 4'b0) begin errors++; $display("FAIL reset_credit_a: got %b expected 0000", credit_a); end
    checks++; if (cnt_a !== 8'h0) begin errors++; $display("FAIL reset_count_a: got %h expected 00", cnt_a); end
    checks++; if (ovf_a !== 4'b0) begin errors++; $display("FAIL reset_ovf_a: got %b expected 0000", ovf_a); end
    checks++; if (vo_m !== 4'b0) begin errors++; $display("FAIL reset_vo_m: got %b expected 0000", vo_m); end
    checks++; if (credit_c !== 4'b0) begin errors++; $display("FAIL reset_credit_c: got %b expected 0000", credit_c); end
    tick();
    rst_n = 1'b1;
    v_a = '0; v_m = '0; v_c = '0;
    rdy_a = '0; rdy_m = '0; rdy_c = '0;
    mid();
    checks++; if ({vo_a, credit_a, ovf_a, cnt_a} !== 20'h0) begin errors++; $display("FAIL release_a: got %h expected 00000", {vo_a, credit_a, ovf_a, cnt_a}); end
    checks++; if ({vo_m, credit_m, cnt_m} !== 16'h0) begin errors++; $display("FAIL release_m: got %h expected 0000", {vo_m, credit_m, cnt_m}); end
    checks++; if ({vo_c, credit_c, cnt_c} !== 16'h0) begin errors++; $display("FAIL release_c: got %h expected 0000", {vo_c, credit_c, cnt_c}); end
  endtask

  task automatic test_latency();
    tick();
    v_a = 4'b0001; din_a[31:0] = 32'hDEAD_BEEF; rdy_a = 4'b0001;
    mid();
    checks++; if (vo_a[0] !== 1'b0) begin errors++; $display("FAIL lat_no_bypass: got %b expected 0", vo_a[0]); end
    tick();
    v_a = '0;
    mid();
    checks++; if (vo_a[0] !== 1'b1) begin errors++; $display("FAIL lat_vo: got %b expected 1", vo_a[0]); end
    checks++; if (dout_a[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat_data: got %h expected deadbeef", dout_a[31:0]); end
    checks++; if (credit_a !== 4'b0001) begin errors++; $display("FAIL lat_credit: got %b expected 0001", credit_a); end
    checks++; if (cnt_a[1:0] !== 2'd1) begin errors++; $display("FAIL lat_count_t1: got %0d expected 1", cnt_a[1:0]); end
    tick();
    mid();
    checks++; if (cnt_a[1:0] !== 2'd0) begin errors++; $display("FAIL lat_count_t2: got %0d expected 0", cnt_a[1:0]); end
    checks++; if ({vo_a[0], credit_a[0]} !== 2'b00) begin errors++; $display("FAIL lat_idle: got %b expected 00", {vo_a[0], credit_a[0]}); end
    rdy_a = '0;
  endtask

  task automatic test_overflow();
    logic [31:0] words [4];
    words[0] = 32'h1111_0001; words[1] = 32'h2222_0002;
    words[2] = 32'h3333_0003; words[3] = 32'h4444_0004;
    rdy_a = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      v_a = 4'b0001; din_a[31:0] = words[i];
    end
    mid();
    checks++; if (cnt_a[1:0] !== 2'd3) begin errors++; $display("FAIL ovf_count_full: got %0d expected 3", cnt_a[1:0]); end
    checks++; if (ovf_a[0] !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b expected 0", ovf_a[0]); end
    tick();
    v_a = '0;
    mid();
    checks++; if (ovf_a !== 4'b0001) begin errors++; $display("FAIL ovf_set: got %b expected 0001", ovf_a); end
    checks++; if (cnt_a[1:0] !== 2'd3) begin errors++; $display("FAIL ovf_count_hold: got %0d expected 3", cnt_a[1:0]); end
    tick();
    rdy_a = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      mid();
      checks++; if (dout_a[31:0] !== words[i] || credit_a[0] !== 1'b1) begin
        errors++; $display("FAIL ovf_drain_%0d: got %h/%b expected %h/1", i, dout_a[31:0], credit_a[0], words[i]);
      end
      tick();
    end
    rdy_a = '0;
    mid();
    checks++; if ({vo_a[0], cnt_a[1:0]} !== 3'b000) begin errors++; $display("FAIL ovf_drained: got %b expected 000", {vo_a[0], cnt_a[1:0]}); end
    checks++; if (ovf_a[0] !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf_a[0]); end
    tick();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    mid();
    checks++; if (ovf_a !== 4'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0000", ovf_a); end
  endtask

  task automatic test_full_simultaneous();
    rdy_a = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      v_a = 4'b0010; din_a[63:32] = 32'hE000_0000 + k;
    end
    tick();
    v_a = 4'b0010; din_a[63:32] = 32'hE000_0003; rdy_a = 4'b0010;
    mid();
    checks++; if (cnt_a[3:2] !== 2'd3) begin errors++; $display("FAIL fs_count_before: got %0d expected 3", cnt_a[3:2]); end
    checks++; if (credit_a !== 4'b0010) begin errors++; $display("FAIL fs_credit: got %b expected 0010", credit_a); end
    checks++; if (dout_a[63:32] !== 32'hE000_0000) begin errors++; $display("FAIL fs_head: got %h expected e0000000", dout_a[63:32]); end
    tick();
    v_a = '0; rdy_a = '0;
    mid();
    checks++; if (cnt_a[3:2] !== 2'd3) begin errors++; $display("FAIL fs_count_after: got %0d expected 3", cnt_a[3:2]); end
    checks++; if (ovf_a[1] !== 1'b0) begin errors++; $display("FAIL fs_no_ovf: got %b expected 0", ovf_a[1]); end
    checks++; if (credit_a !== 4'b0) begin errors++; $display("FAIL fs_single_credit: got %b expected 0000", credit_a); end
    tick();
    rdy_a = 4'b0010;
    for (int k = 1; k < 4; k++) begin
      mid();
      checks++; if (dout_a[63:32] !== 32'hE000_0000 + k) begin
        errors++; $display("FAIL fs_order_%0d: got %h expected %h", k, dout_a[63:32], 32'hE000_0000 + k);
      end
      tick();
    end
    rdy_a = '0;
    mid();
    checks++; if (cnt_a[3:2] !== 2'd0) begin errors++; $display("FAIL fs_drained: got %0d expected 0", cnt_a[3:2]); end
  endtask

  task automatic test_merge_order();
    rdy_m = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      v_m = 4'b1111;
      for (int c = 0; c < 4; c++) din_m[c*32 +: 32] = 32'hA000_0000 + c*16 + k;
    end
    tick();
    v_m = '0;
    mid();
    checks++; if (cnt_m !== 8'b10_10_10_10) begin errors++; $display("FAIL mo_preload: got %b expected 10101010", cnt_m); end
    tick();
    rdy_m = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      mid();
      checks++; if (vo_m !== 4'b0001 || dout_m[31:0] !== 32'hA000_0000 + (i % 4)*16 + (i / 4)) begin
        errors++; $display("FAIL mo_seq_%0d: got %b/%h expected 0001/%h", i, vo_m, dout_m[31:0], 32'hA000_0000 + (i % 4)*16 + (i / 4));
      end
      tick();
    end
    rdy_m = '0;
    mid();
    checks++; if (vo_m !== 4'b0) begin errors++; $display("FAIL mo_empty: got %b expected 0000", vo_m); end
  endtask

  task automatic test_merge_lock();
    tick();
    v_m = 4'b0100; din_m[95:64] = 32'hC2C2_0002;
    tick();
    v_m = 4'b0001; din_m[31:0] = 32'hC0C0_0000;
    mid();
    checks++; if (vo_m[0] !== 1'b1 || dout_m[31:0] !== 32'hC2C2_0002) begin
      errors++; $display("FAIL ml_first: got %b/%h expected 1/c2c20002", vo_m[0], dout_m[31:0]);
    end
    tick();
    v_m = '0;
    for (int i = 0; i < 5; i++) begin
      mid();
      checks++; if (vo_m !== 4'b0001 || dout_m[31:0] !== 32'hC2C2_0002) begin
        errors++; $display("FAIL ml_stable_%0d: got %b/%h expected 0001/c2c20002", i, vo_m, dout_m[31:0]);
      end
      tick();
    end
    rdy_m = 4'b0001;
    mid();
    checks++; if (dout_m[31:0] !== 32'hC2C2_0002 || credit_m !== 4'b0100) begin
      errors++; $display("FAIL ml_hs: got %h/%b expected c2c20002/0100", dout_m[31:0], credit_m);
    end
    tick();
    mid();
    checks++; if (dout_m[31:0] !== 32'hC0C0_0000 || credit_m !== 4'b0001) begin
      errors++; $display("FAIL ml_next: got %h/%b expected c0c00000/0001", dout_m[31:0], credit_m);
    end
    tick();
    rdy_m = '0;
    mid();
    checks++; if (vo_m !== 4'b0) begin errors++; $display("FAIL ml_empty: got %b expected 0000", vo_m); end
  endtask

  task automatic test_credit_reg();
    tick();
    v_c = 4'b0001; din_c[31:0] = 32'h5A5A_1234; rdy_c = 4'b0001;
    mid();
    checks++; if ({vo_c[0], credit_c[0]} !== 2'b00) begin errors++; $display("FAIL cr_t0: got %b expected 00", {vo_c[0], credit_c[0]}); end
    tick();
    v_c = '0;
    mid();
    checks++; if (vo_c[0] !== 1'b1 || dout_c[31:0] !== 32'h5A5A_1234 || credit_c !== 4'b0) begin
      errors++; $display("FAIL cr_hs_cycle: got %b/%h/%b expected 1/5a5a1234/0000", vo_c[0], dout_c[31:0], credit_c);
    end
    tick();
    mid();
    checks++; if (credit_c !== 4'b0001) begin errors++; $display("FAIL cr_pulse: got %b expected 0001", credit_c); end
    tick();
    mid();
    checks++; if (credit_c !== 4'b0) begin errors++; $display("FAIL cr_pulse_end: got %b expected 0000", credit_c); end
    rdy_c = '0;
  endtask

  task automatic test_async_reset();
    rdy_c = '0;
    tick();
    v_c = 4'b0001; din_c[31:0] = 32'h0BAD_0000;
    tick();
    din_c[31:0] = 32'h0BAD_0001;
    tick();
    v_c = '0;
    mid();
    checks++; if (cnt_c[1:0] !== 2'd2 || vo_c[0] !== 1'b1) begin
      errors++; $display("FAIL ar_loaded: got %0d/%b expected 2/1", cnt_c[1:0], vo_c[0]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (vo_c !== 4'b0 || cnt_c !== 8'h0) begin
      errors++; $display("FAIL ar_async: got %b/%h expected 0000/00", vo_c, cnt_c);
    end
    tick();
    tick();
    rst_n = 1'b1;
    mid();
    checks++; if ({vo_c, credit_c, cnt_c} !== 16'h0) begin
      errors++; $display("FAIL ar_release: got %h expected 0000", {vo_c, credit_c, cnt_c});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_full_simultaneous();
    test_merge_order();
    test_merge_lock();
    test_credit_reg();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
